// File: rtl/ram_bank_pkg.sv
// ram_bank_pkg: shared types and helpers for the RAM bank ring controller.
//   wr_state_t / rd_state_t : write-side and read-side handshake FSM states
//   MAX_RETRY_DEFAULT       : default number of send attempts per frame
//   sat_inc8                : 8-bit increment that sticks at 255
//   bank_base               : bank index -> RAM byte base address
package ram_bank_pkg;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_MAKE = 2'd1,
      W_REL  = 2'd2
   } wr_state_t;

   typedef enum logic [1:0] {
      R_IDLE = 2'd0,
      R_SEND = 2'd1,
      R_REL  = 2'd2
   } rd_state_t;

   localparam int MAX_RETRY_DEFAULT = 3;

   function automatic logic [7:0] sat_inc8(input logic [7:0] value);
      logic [7:0] result;
      if (value == 8'hFF) begin
         result = value;
      end else begin
         result = value + 8'd1;
      end
      return result;
   endfunction

   // Banks are equal power-of-two slices, so the base is the index shifted
   // up by the bank-offset width.
   function automatic logic [31:0] bank_base(input logic [31:0] ptr, input int shift);
      return ptr << shift;
   endfunction

endpackage

// File: rtl/ram_bank_ctrl_bank_ring.sv
// bank_ring: ring bookkeeping for the banked frame buffer.
//   clk, rst_n        : clock, synchronous active-low reset
//   alloc, alloc_len  : reserve the bank at wr_ptr and record its length
//   commit            : bank at wr_ptr is filled; advance wr_ptr, full++
//   free              : bank at rd_ptr is done; advance rd_ptr, full--, used--
//   wr_ptr, rd_ptr    : fill and send bank indices
//   used, full        : banks reserved (filling+full+sending), banks full
//   rd_len            : stored length of the bank at rd_ptr
module bank_ring
   import ram_bank_pkg::*;
#(
   parameter int BANK_BITS = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 alloc,
   input  logic [11:0]          alloc_len,
   input  logic                 commit,
   input  logic                 free,
   output logic [BANK_BITS-1:0] wr_ptr,
   output logic [BANK_BITS-1:0] rd_ptr,
   output logic [BANK_BITS:0]   used,
   output logic [BANK_BITS:0]   full,
   output logic [11:0]          rd_len
);

   localparam int NBANK = 2**BANK_BITS;

   logic [BANK_BITS-1:0] wr_ptr_r;
   logic [BANK_BITS-1:0] rd_ptr_r;
   logic [BANK_BITS:0]   used_r;
   logic [BANK_BITS:0]   full_r;
   logic [11:0]          blen_r [NBANK];

   // Pointer, occupancy and length-table update; simultaneous strobes net out.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_r <= {BANK_BITS{1'b0}};
         rd_ptr_r <= {BANK_BITS{1'b0}};
         used_r   <= {(BANK_BITS+1){1'b0}};
         full_r   <= {(BANK_BITS+1){1'b0}};
         for (int i = 0; i < NBANK; i++) begin
            blen_r[i] <= 12'd0;
         end
      end else begin
         if (alloc) begin
            blen_r[wr_ptr_r] <= alloc_len;
         end
         if (commit) begin
            wr_ptr_r <= wr_ptr_r + {{(BANK_BITS-1){1'b0}}, 1'b1};
         end
         if (free) begin
            rd_ptr_r <= rd_ptr_r + {{(BANK_BITS-1){1'b0}}, 1'b1};
         end
         used_r <= used_r + {{BANK_BITS{1'b0}}, alloc}  - {{BANK_BITS{1'b0}}, free};
         full_r <= full_r + {{BANK_BITS{1'b0}}, commit} - {{BANK_BITS{1'b0}}, free};
      end
   end

   assign wr_ptr = wr_ptr_r;
   assign rd_ptr = rd_ptr_r;
   assign used   = used_r;
   assign full   = full_r;
   assign rd_len = blen_r[rd_ptr_r];

endmodule

// File: rtl/ram_bank_ctrl.sv
// ram_bank_ctrl: ping-pong/ring sequencer between data_make (writer) and
// com (reader) over a RAM split into 2**BANK_BITS equal banks.
//   clk, rst_n             : clock, synchronous active-low reset
//   fill_req, fill_dlen    : new-frame pulse and its byte length
//   fs_make, make_addr     : start writer into bank at make_addr
//   fd_make                : writer done
//   fs_send, send_addr,
//   send_dlen              : start reader on bank at send_addr, send_dlen bytes
//   fd_send, fd_txer       : reader done, with error flag
//   bank_used              : banks filling, full or sending
//   drop_cnt, err_cnt      : saturating counts of rejected / discarded frames
module ram_bank_ctrl
   import ram_bank_pkg::*;
#(
   parameter int ADDR_W    = 12,
   parameter int BANK_BITS = 2,
   parameter int MAX_RETRY = MAX_RETRY_DEFAULT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              fill_req,
   input  logic [11:0]       fill_dlen,
   output logic              fs_make,
   output logic [ADDR_W-1:0] make_addr,
   input  logic              fd_make,
   output logic              fs_send,
   output logic [ADDR_W-1:0] send_addr,
   output logic [11:0]       send_dlen,
   input  logic              fd_send,
   input  logic              fd_txer,
   output logic [BANK_BITS:0] bank_used,
   output logic [7:0]        drop_cnt,
   output logic [7:0]        err_cnt
);

   localparam int                 NBANK       = 2**BANK_BITS;
   localparam int                 SHIFT       = ADDR_W - BANK_BITS;
   localparam logic [12:0]        BSZ         = 13'(2**SHIFT);
   localparam logic [BANK_BITS:0] NBANK_V     = NBANK[BANK_BITS:0];
   localparam logic [7:0]         MAX_RETRY_V = 8'(MAX_RETRY);

   wr_state_t wr_state_r, wr_next_s;
   rd_state_t rd_state_r, rd_next_s;

   logic                 accept_s, drop_s, commit_s;
   logic                 load_s, free_s, retry_inc_s, err_s;
   logic [11:0]          clamp_len_s;
   logic [BANK_BITS-1:0] wr_ptr_s, rd_ptr_s;
   logic [BANK_BITS:0]   used_s, full_s;
   logic [11:0]          rd_len_s;

   logic              fs_make_r, fs_send_r;
   logic [ADDR_W-1:0] make_addr_r, send_addr_r;
   logic [11:0]       send_dlen_r;
   logic [7:0]        retry_r, drop_cnt_r, err_cnt_r;

   bank_ring #(.BANK_BITS(BANK_BITS)) u_ring (
      .clk       (clk),
      .rst_n     (rst_n),
      .alloc     (accept_s),
      .alloc_len (clamp_len_s),
      .commit    (commit_s),
      .free      (free_s),
      .wr_ptr    (wr_ptr_s),
      .rd_ptr    (rd_ptr_s),
      .used      (used_s),
      .full      (full_s),
      .rd_len    (rd_len_s)
   );

   // Frame length is limited to one bank.
   always_comb begin
      clamp_len_s = fill_dlen;
      if ({1'b0, fill_dlen} > BSZ) begin
         clamp_len_s = BSZ[11:0];
      end else begin
         clamp_len_s = fill_dlen;
      end
   end

   // Write FSM next state, acceptance and drop decision (uses pre-update used).
   always_comb begin
      wr_next_s = wr_state_r;
      accept_s  = 1'b0;
      drop_s    = 1'b0;
      commit_s  = 1'b0;
      case (wr_state_r)
         W_IDLE: begin
            if (fill_req && (fill_dlen != 12'd0)) begin
               if (used_s == NBANK_V) begin
                  drop_s = 1'b1;
               end else begin
                  accept_s  = 1'b1;
                  wr_next_s = W_MAKE;
               end
            end else begin
               wr_next_s = W_IDLE;
            end
         end
         W_MAKE: begin
            drop_s = fill_req;
            if (fd_make) begin
               commit_s  = 1'b1;
               wr_next_s = W_REL;
            end else begin
               wr_next_s = W_MAKE;
            end
         end
         W_REL: begin
            drop_s = fill_req;
            if (!fd_make) begin
               wr_next_s = W_IDLE;
            end else begin
               wr_next_s = W_REL;
            end
         end
         default: begin
            wr_next_s = W_IDLE;
         end
      endcase
   end

   // Read FSM next state and send-result handling; a kept bank is re-sent
   // from R_IDLE because rd_ptr does not move.
   always_comb begin
      rd_next_s   = rd_state_r;
      load_s      = 1'b0;
      free_s      = 1'b0;
      retry_inc_s = 1'b0;
      err_s       = 1'b0;
      case (rd_state_r)
         R_IDLE: begin
            if (full_s != {(BANK_BITS+1){1'b0}}) begin
               load_s    = 1'b1;
               rd_next_s = R_SEND;
            end else begin
               rd_next_s = R_IDLE;
            end
         end
         R_SEND: begin
            if (fd_send) begin
               rd_next_s = R_REL;
               if (!fd_txer) begin
                  free_s = 1'b1;
               end else if ((retry_r + 8'd1) < MAX_RETRY_V) begin
                  retry_inc_s = 1'b1;
               end else begin
                  free_s = 1'b1;
                  err_s  = 1'b1;
               end
            end else begin
               rd_next_s = R_SEND;
            end
         end
         R_REL: begin
            if (!fd_send) begin
               rd_next_s = R_IDLE;
            end else begin
               rd_next_s = R_REL;
            end
         end
         default: begin
            rd_next_s = R_IDLE;
         end
      endcase
   end

   // FSM state registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_state_r <= W_IDLE;
         rd_state_r <= R_IDLE;
      end else begin
         wr_state_r <= wr_next_s;
         rd_state_r <= rd_next_s;
      end
   end

   // Registered handshake outputs; addresses/length latch on entry so they
   // stay stable for the whole fs pulse.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fs_make_r   <= 1'b0;
         fs_send_r   <= 1'b0;
         make_addr_r <= {ADDR_W{1'b0}};
         send_addr_r <= {ADDR_W{1'b0}};
         send_dlen_r <= 12'd0;
      end else begin
         fs_make_r <= (wr_next_s == W_MAKE);
         fs_send_r <= (rd_next_s == R_SEND);
         if (accept_s) begin
            make_addr_r <= ADDR_W'(bank_base(32'(wr_ptr_s), SHIFT));
         end
         if (load_s) begin
            send_addr_r <= ADDR_W'(bank_base(32'(rd_ptr_s), SHIFT));
            send_dlen_r <= rd_len_s;
         end
      end
   end

   // Retry tracking and saturating event counters.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         retry_r    <= 8'd0;
         drop_cnt_r <= 8'd0;
         err_cnt_r  <= 8'd0;
      end else begin
         if (free_s) begin
            retry_r <= 8'd0;
         end else if (retry_inc_s) begin
            retry_r <= retry_r + 8'd1;
         end
         if (drop_s) begin
            drop_cnt_r <= sat_inc8(drop_cnt_r);
         end
         if (err_s) begin
            err_cnt_r <= sat_inc8(err_cnt_r);
         end
      end
   end

   assign fs_make   = fs_make_r;
   assign fs_send   = fs_send_r;
   assign make_addr = make_addr_r;
   assign send_addr = send_addr_r;
   assign send_dlen = send_dlen_r;
   assign bank_used = used_s;
   assign drop_cnt  = drop_cnt_r;
   assign err_cnt   = err_cnt_r;

endmodule
